signed_peak_tracker: RTL and testbench

//   Streaming consumer of the signed >= comparator: accepts signed WIDTH-bit samples over a

---
 rtl/signed_peak_tracker_pkg.sv | 23 ++
 rtl/signed_peak_tracker_if.sv | 28 ++
 rtl/signed_peak_tracker_sge_cmp.sv | 25 ++
 rtl/signed_peak_tracker.sv | 104 ++++++++++
 tb/tb_signed_peak_tracker.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/signed_peak_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : signed_cmp_pkg
// Purpose  : Shared state encoding and signed >= decode for the peak tracker.
// Revision : 1.0 - initial release
// ============================================================================
package signed_cmp_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Signs differ: the non-negative operand is larger. Signs equal: the
  // subtraction cannot overflow, so the difference sign decides.
  function automatic logic sge_decode(input logic diff_neg,
                                      input logic a_neg,
                                      input logic b_neg);
    return (a_neg ^ b_neg) ? ~a_neg : ~diff_neg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/signed_peak_tracker_if.sv
`default_nettype none
// ============================================================================
// Module   : signed_peak_tracker_if
// Purpose  : Sample input and result output handshakes of the peak tracker.
// Revision : 1.0 - initial release
// ============================================================================
interface signed_peak_tracker_if #(
  parameter int WIDTH = 4
);
  logic signed [WIDTH-1:0] i;
  logic                    i_valid;
  logic                    i_ready;
  logic signed [WIDTH-1:0] max;
  logic signed [WIDTH-1:0] min;
  logic                    o_valid;
  logic                    o_ready;

  modport master (
    output i, i_valid, o_ready,
    input  i_ready, max, min, o_valid
  );

  modport slave (
    input  i, i_valid, o_ready,
    output i_ready, max, min, o_valid
  );
endinterface
`default_nettype wire

// File: rtl/signed_peak_tracker_sge_cmp.sv
`default_nettype none
// ============================================================================
// Module   : sge_cmp
// Purpose  : Combinational signed i0 >= i1 at full width, overflow-safe.
// Revision : 1.0 - initial release
// ============================================================================
module sge_cmp
  import signed_cmp_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  wire logic signed [WIDTH-1:0] i0,
  input  wire logic signed [WIDTH-1:0] i1,
  output logic                         o
);

  logic signed [WIDTH-1:0] w_diff;
  logic                    w_diff_neg;

  assign w_diff     = i0 - i1;
  assign w_diff_neg = (w_diff < 0);
  assign o          = sge_decode(w_diff_neg, i0[WIDTH-1], i1[WIDTH-1]);

endmodule
`default_nettype wire

// File: rtl/signed_peak_tracker.sv
`default_nettype none
// ============================================================================
// Module   : signed_peak_tracker
// Purpose  : Running signed max/min over fixed windows of WINDOW samples.
// Revision : 1.0 - initial release
// ============================================================================
module signed_peak_tracker
  import signed_cmp_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int WINDOW = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clr,
  signed_peak_tracker_if.slave  bus
);

  localparam int             CW     = $clog2(WINDOW + 1);
  localparam logic [CW-1:0]  C_LAST = CW'(WINDOW - 1);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [CW-1:0]           r_count;
  logic [CW-1:0]           w_next_count;
  logic signed [WIDTH-1:0] r_max;
  logic signed [WIDTH-1:0] r_min;
  logic signed [WIDTH-1:0] w_next_max;
  logic signed [WIDTH-1:0] w_next_min;
  logic                    r_o_valid;
  logic                    w_accept;
  logic                    w_ge_max;
  logic                    w_ge_min;

  sge_cmp #(.WIDTH(WIDTH)) u_sge_max (
    .i0 (bus.i),
    .i1 (r_max),
    .o  (w_ge_max)
  );

  sge_cmp #(.WIDTH(WIDTH)) u_sge_min (
    .i0 (bus.i),
    .i1 (r_min),
    .o  (w_ge_min)
  );

  assign bus.i_ready = (r_state == ACCUM) & ~rst;
  assign w_accept    = bus.i_valid & bus.i_ready;
  assign bus.o_valid = r_o_valid;
  assign bus.max     = r_max;
  assign bus.min     = r_min;

  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    w_next_max   = r_max;
    w_next_min   = r_min;
    if (clr) begin
      w_next_state = ACCUM;
      w_next_count = '0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            if (r_count == '0) begin
              w_next_max = bus.i;
              w_next_min = bus.i;
            end else begin
              if (w_ge_max)  w_next_max = bus.i;
              if (!w_ge_min) w_next_min = bus.i;
            end
            w_next_count = r_count + CW'(1);
            if (r_count == C_LAST) w_next_state = HOLD;
          end
        end
        HOLD: begin
          if (bus.o_ready) begin
            w_next_state = ACCUM;
            w_next_count = '0;
          end
        end
        default: w_next_state = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ACCUM;
      r_count   <= '0;
      r_max     <= '0;
      r_min     <= '0;
      r_o_valid <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_count   <= w_next_count;
      r_max     <= w_next_max;
      r_min     <= w_next_min;
      r_o_valid <= (w_next_state == HOLD);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_signed_peak_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_signed_peak_tracker
// Purpose  : Directed vectors for the peak tracker, WINDOW=4 and WINDOW=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_signed_peak_tracker;

  logic clk = 1'b0;
  logic rst;
  logic clr;

  signed_peak_tracker_if #(.WIDTH(4)) bus4 ();
  signed_peak_tracker_if #(.WIDTH(4)) bus1 ();

  signed_peak_tracker #(.WIDTH(4), .WINDOW(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus4.slave)
  );

  signed_peak_tracker #(.WIDTH(4), .WINDOW(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .bus (bus1.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s0;
    int s1;
    int s2;
    int s3;
    int emax;
    int emin;
  } vec_t;

  vec_t vecs[6];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input integer act, input integer exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int idx, input int a, input int b, input int c,
                         input int d, input int mx, input int mn);
    vecs[idx].s0   = a;
    vecs[idx].s1   = b;
    vecs[idx].s2   = c;
    vecs[idx].s3   = d;
    vecs[idx].emax = mx;
    vecs[idx].emin = mn;
  endtask

  // Four back-to-back accepts; returns right after the edge of the last accept.
  task automatic send_window(input int a, input int b, input int c, input int d,
                             input logic ordy);
    int s[4];
    s[0] = a; s[1] = b; s[2] = c; s[3] = d;
    for (int k = 0; k < 4; k++) begin
      bus4.i       = 4'(s[k]);
      bus4.i_valid = 1'b1;
      bus4.o_ready = ordy;
      chk("i_ready_accum", bus4.i_ready, 1);
      chk("o_valid_accum", bus4.o_valid, 0);
      tick();
    end
    bus4.i_valid = 1'b0;
  endtask

  initial begin
    set_vec(0,  3, -8,  7, -1,  7, -8);
    set_vec(1, -5, -5, -5, -5, -5, -5);
    set_vec(2,  7, -8, -8,  7,  7, -8);
    set_vec(3,  1,  2,  0, -1,  2, -1);
    set_vec(4,  0,  1, -1,  0,  1, -1);
    set_vec(5, -8, -8, -8, -7, -7, -8);

    rst = 1'b1; clr = 1'b0;
    bus4.i = '0; bus4.i_valid = 1'b0; bus4.o_ready = 1'b0;
    bus1.i = '0; bus1.i_valid = 1'b0; bus1.o_ready = 1'b0;
    tick();
    tick();
    chk("reset_i_ready", bus4.i_ready, 0);
    chk("reset_o_valid", bus4.o_valid, 0);
    chk("reset_max", bus4.max, 0);
    chk("reset_min", bus4.min, 0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      send_window(vecs[v].s0, vecs[v].s1, vecs[v].s2, vecs[v].s3, 1'b1);
      chk("tbl_o_valid", bus4.o_valid, 1);
      chk("tbl_max", bus4.max, vecs[v].emax);
      chk("tbl_min", bus4.min, vecs[v].emin);
      tick();
      chk("tbl_o_valid_clear", bus4.o_valid, 0);
      chk("tbl_i_ready_after", bus4.i_ready, 1);
    end

    // Backpressure in HOLD with a sample waiting on the input.
    send_window(2, 4, -3, 1, 1'b0);
    chk("bp_o_valid", bus4.o_valid, 1);
    bus4.i = 4'(6);
    bus4.i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_i_ready", bus4.i_ready, 0);
      chk("bp_o_valid_hold", bus4.o_valid, 1);
      chk("bp_max", bus4.max, 4);
      chk("bp_min", bus4.min, -3);
      tick();
    end
    bus4.o_ready = 1'b1;
    chk("bp_i_ready_hs", bus4.i_ready, 0);
    tick();
    bus4.i_valid = 1'b0;
    chk("bp_o_valid_clear", bus4.o_valid, 0);
    send_window(1, 1, 1, 1, 1'b1);
    chk("bp_next_o_valid", bus4.o_valid, 1);
    chk("bp_next_max", bus4.max, 1);
    chk("bp_next_min", bus4.min, 1);
    tick();

    // CLR mid-window; the sample offered with CLR is dropped.
    bus4.i = 4'(-3); bus4.i_valid = 1'b1;
    tick();
    bus4.i = 4'(5);
    tick();
    clr = 1'b1; bus4.i = 4'(4);
    tick();
    clr = 1'b0; bus4.i_valid = 1'b0;
    chk("clr_o_valid", bus4.o_valid, 0);
    chk("clr_i_ready", bus4.i_ready, 1);
    send_window(1, 2, 0, -1, 1'b1);
    chk("clr_win_o_valid", bus4.o_valid, 1);
    chk("clr_win_max", bus4.max, 2);
    chk("clr_win_min", bus4.min, -1);
    tick();

    // CLR while holding a result.
    send_window(5, 5, 5, 5, 1'b0);
    chk("clrh_o_valid", bus4.o_valid, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clrh_o_valid_clear", bus4.o_valid, 0);
    chk("clrh_i_ready", bus4.i_ready, 1);

    // Asynchronous reset between edges while in HOLD.
    send_window(3, -8, 7, -1, 1'b0);
    chk("ar_o_valid", bus4.o_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_o_valid_async", bus4.o_valid, 0);
    chk("ar_max_async", bus4.max, 0);
    chk("ar_min_async", bus4.min, 0);
    chk("ar_i_ready_async", bus4.i_ready, 0);
    rst = 1'b0;
    tick();
    chk("ar_i_ready_after", bus4.i_ready, 1);
    send_window(-1, -2, 3, -4, 1'b1);
    chk("ar_win_max", bus4.max, 3);
    chk("ar_win_min", bus4.min, -4);
    tick();

    // WINDOW=1: each accept goes straight to HOLD.
    bus1.i = 4'(-2); bus1.i_valid = 1'b1; bus1.o_ready = 1'b0;
    chk("w1_i_ready", bus1.i_ready, 1);
    tick();
    bus1.i_valid = 1'b0;
    chk("w1_o_valid", bus1.o_valid, 1);
    chk("w1_max", bus1.max, -2);
    chk("w1_min", bus1.min, -2);
    chk("w1_i_ready_hold", bus1.i_ready, 0);
    bus1.o_ready = 1'b1;
    tick();
    chk("w1_o_valid_clear", bus1.o_valid, 0);
    bus1.i = 4'(5); bus1.i_valid = 1'b1;
    tick();
    bus1.i_valid = 1'b0;
    chk("w1b_max", bus1.max, 5);
    chk("w1b_min", bus1.min, 5);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
